// File: rtl/y86_pkg.sv
// Y86-64 encodings shared by the hazard controller, its interface and the bench.
package y86_pkg;

  localparam int unsigned Y86_REG_W   = 4;
  localparam int unsigned Y86_ICODE_W = 4;
  localparam int unsigned Y86_STAT_W  = 4;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // One-hot status codes, AOK in the MSB
  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } ctrl_state_t;

  // True for instructions that load a register from memory in the memory stage
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_v2_if.sv
// Pipeline-side view of the hazard controller.
//   master : pipeline (drives stage icodes/regs/status, perf_clr; receives controls, counters)
//   slave  : hazard controller
interface pipe_hazard_ctrl_v2_if #(
  parameter int unsigned REG_W   = y86_pkg::Y86_REG_W,
  parameter int unsigned ICODE_W = y86_pkg::Y86_ICODE_W,
  parameter int unsigned STAT_W  = y86_pkg::Y86_STAT_W,
  parameter int unsigned CNT_W   = 32
);

  logic [ICODE_W-1:0] D_icode;
  logic [REG_W-1:0]   d_srcA;
  logic [REG_W-1:0]   d_srcB;
  logic [ICODE_W-1:0] E_icode;
  logic [REG_W-1:0]   E_destM;
  logic               e_Cnd;
  logic [ICODE_W-1:0] M_icode;
  logic [STAT_W-1:0]  m_stat;
  logic [ICODE_W-1:0] W_icode;
  logic [STAT_W-1:0]  W_stat;
  logic               perf_clr;

  logic               setcc;
  logic               F_stall;
  logic               D_stall;
  logic               D_bubble;
  logic               E_bubble;
  logic               M_bubble;
  logic               W_stall;
  logic               halted;
  logic [CNT_W-1:0]   cnt_cycle;
  logic [CNT_W-1:0]   cnt_retire;
  logic [CNT_W-1:0]   cnt_ldu;
  logic [CNT_W-1:0]   cnt_misp;
  logic [CNT_W-1:0]   cnt_ret;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_destM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat, perf_clr,
    input  setcc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted,
           cnt_cycle, cnt_retire, cnt_ldu, cnt_misp, cnt_ret
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_destM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat, perf_clr,
    output setcc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted,
           cnt_cycle, cnt_retire, cnt_ldu, cnt_misp, cnt_ret
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear
//   inc      : count enable
//   q        : registered count, holds at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl_v2.sv
// Y86-64 pipeline hazard controller: stall/bubble/setcc generation, exception
// freeze FSM and saturating performance counters.
//   clk, rst : clock, async active-high reset
//   bus      : pipe_hazard_ctrl_v2_if.slave (stage inputs, pipe controls, counters)
module pipe_hazard_ctrl_v2
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_v2_if.slave  bus
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic w_lu;
  logic w_ret;
  logic w_misp;
  logic w_wbad;
  logic w_exc;
  logic w_run;

  // Hazard terms; RNONE as a load destination can never collide with a source
  assign w_lu   = is_load(bus.E_icode) && (bus.E_destM != RNONE) &&
                  ((bus.E_destM == bus.d_srcA) || (bus.E_destM == bus.d_srcB));
  assign w_ret  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
  assign w_misp = (bus.E_icode == I_JXX) && !bus.e_Cnd;
  assign w_wbad = (bus.W_stat != STAT_AOK);
  assign w_exc  = (bus.m_stat != STAT_AOK) || w_wbad;
  assign w_run  = (r_state == S_RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: freeze once a faulting instruction reaches writeback
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_wbad) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Pipe controls; combinational so hazards act in the same cycle
  always_comb begin
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b0;
    bus.setcc    = 1'b0;
    bus.halted   = 1'b0;
    if (rst) begin
      bus.D_bubble = 1'b1;
      bus.E_bubble = 1'b1;
      bus.M_bubble = 1'b1;
    end else if (r_state == S_HALT) begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.W_stall  = 1'b1;
      bus.halted   = 1'b1;
    end else begin
      bus.F_stall  = w_lu | w_ret;
      bus.D_stall  = w_lu;
      // A load/use stall must hold decode, so ret only bubbles decode without one
      bus.D_bubble = w_misp | (w_ret & !w_lu);
      bus.E_bubble = w_misp | w_lu;
      bus.M_bubble = w_exc;
      bus.W_stall  = w_wbad;
      bus.setcc    = !((bus.E_icode == I_HALT) | w_exc);
    end
  end

  // Performance counters, counting only while running
  sat_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
    .clk(clk), .rst(rst), .clr(bus.perf_clr),
    .inc(w_run),
    .q(bus.cnt_cycle)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_retire (
    .clk(clk), .rst(rst), .clr(bus.perf_clr),
    .inc(w_run && (bus.W_icode != I_NOP) && !w_wbad),
    .q(bus.cnt_retire)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_ldu (
    .clk(clk), .rst(rst), .clr(bus.perf_clr),
    .inc(w_run && w_lu && !w_exc),
    .q(bus.cnt_ldu)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_misp (
    .clk(clk), .rst(rst), .clr(bus.perf_clr),
    .inc(w_run && w_misp && !w_exc),
    .q(bus.cnt_misp)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_ret (
    .clk(clk), .rst(rst), .clr(bus.perf_clr),
    .inc(w_run && w_ret && !w_exc),
    .q(bus.cnt_ret)
  );

endmodule
